// File: rtl/layer2_backward.sv
// Backward pass for the 32->10 output layer: output deltas, then W^T*delta, on one time-shared MAC.
// Optional macro BP_SAT_EN: every 16-bit narrowing clamps instead of wrapping.
module layer2_backward #(
  parameter int N_OUT = 10,
  parameter int N_HID = 32,
  parameter int FRAC  = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic signed [15:0] outputLayer [N_OUT],
  input  logic signed [15:0] target      [N_OUT],
  input  logic signed [15:0] weights     [N_OUT*N_HID],
  output logic signed [15:0] delta       [N_OUT],
  output logic signed [15:0] hiddenErr   [N_HID],
  output logic               busy,
  output logic               done
);
  localparam int KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int JW = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int IW = ((N_OUT * N_HID) > 1) ? $clog2(N_OUT * N_HID) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_OUT - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N_HID - 1);
  localparam logic signed [39:0] ONE = 40'sd1 <<< FRAC;

  typedef enum logic [1:0] {IDLE, DELTA, BACK, DONE} state_t;

  state_t             state;
  logic [KW-1:0]      k;
  logic [JW-1:0]      j;
  logic signed [39:0] acc;
  logic signed [15:0] y_reg [N_OUT];
  logic signed [15:0] t_reg [N_OUT];

  function automatic logic signed [15:0] sat16(input logic signed [39:0] v);
`ifdef BP_SAT_EN
    if (v > 40'sd32767)
      return 16'sh7FFF;
    else if (v < -40'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
`else
    return v[15:0];
`endif
  endfunction

  logic signed [15:0] y_k, t_k, e, d1, one_minus_y, d_k, w_kj, mul_a, mul_b;
  logic signed [31:0] prod, prod2;
  logic signed [39:0] mac_sum;
  logic [IW-1:0]      widx;

  // The shared multiplier forms e*y while computing deltas and w*delta while back-propagating.
  always_comb begin
    y_k         = y_reg[k];
    t_k         = t_reg[k];
    widx        = IW'(int'(k) * N_HID + int'(j));
    w_kj        = weights[widx];
    e           = sat16(40'(y_k) - 40'(t_k));
    mul_a       = (state == BACK) ? w_kj : e;
    mul_b       = (state == BACK) ? delta[k] : y_k;
    prod        = mul_a * mul_b;
    d1          = sat16(40'(prod) >>> FRAC);
    one_minus_y = sat16(ONE - 40'(y_k));
    prod2       = d1 * one_minus_y;
    d_k         = sat16(40'(prod2) >>> FRAC);
    mac_sum     = acc + 40'(prod);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      j     <= '0;
      acc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < N_OUT; i++) begin
        y_reg[i] <= '0;
        t_reg[i] <= '0;
        delta[i] <= '0;
      end
      for (int i = 0; i < N_HID; i++) hiddenErr[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            y_reg <= outputLayer;
            t_reg <= target;
            k     <= '0;
            j     <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= DELTA;
          end
        end
        DELTA: begin
          delta[k] <= d_k;
          if (k == K_LAST) begin
            k     <= '0;
            state <= BACK;
          end else begin
            k <= k + 1'b1;
          end
        end
        BACK: begin
          // Fold the last product in directly so the accumulator never holds a finished sum.
          if (k == K_LAST) begin
            hiddenErr[j] <= sat16(mac_sum >>> FRAC);
            acc          <= '0;
            k            <= '0;
            if (j == J_LAST) state <= DONE;
            else             j     <= j + 1'b1;
          end else begin
            acc <= mac_sum;
            k   <= k + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_layer2_backward.sv
// Testbench for layer2_backward: directed vector table, multi-cycle corner sequences, random runs vs. arithmetic model.
module tb_layer2_backward;
  localparam int N_OUT = 10;
  localparam int N_HID = 32;
  localparam int N_W   = N_OUT * N_HID;
  localparam int DONE_EDGE = 331;

  logic clk = 1'b0;
  logic rst;
  logic run;
  logic signed [15:0] y_in  [N_OUT];
  logic signed [15:0] t_in  [N_OUT];
  logic signed [15:0] w_in  [N_W];
  logic signed [15:0] delta [N_OUT];
  logic signed [15:0] hid   [N_HID];
  logic busy, done;

  int checks = 0;
  int errors = 0;

  layer2_backward #(.N_OUT(N_OUT), .N_HID(N_HID), .FRAC(12)) dut (
    .clk(clk), .rst(rst), .run(run),
    .outputLayer(y_in), .target(t_in), .weights(w_in),
    .delta(delta), .hiddenErr(hid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] y, t, t3, w;
    bit          one_hot;
    logic [15:0] ed, ed3, eh, eh5;
  } vec_t;

  vec_t vecs [4];
  longint exp_d [N_OUT];
  longint exp_h [N_HID];

`ifdef BP_SAT_EN
  localparam logic [15:0] SAT_D = 16'h7FFF;
  localparam logic [15:0] SAT_H = 16'h004F;
`else
  localparam logic [15:0] SAT_D = 16'h0038;
  localparam logic [15:0] SAT_H = 16'h0000;
`endif

  task automatic check(input string nm, input int idx, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", nm, idx, act, expv);
    end
  endtask

  // Narrowing to 16 bits exactly as the arithmetic rules describe for the selected build.
  function automatic longint fx(input longint v);
`ifdef BP_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    longint m;
    m = v & 64'hFFFF;
    return (m >= 32768) ? m - 65536 : m;
`endif
  endfunction

  function automatic longint sx(input logic [15:0] x);
    return longint'($signed(x));
  endfunction

  task automatic compute_model();
    longint y, t, e, d1, om, acc;
    for (int kk = 0; kk < N_OUT; kk++) begin
      y  = sx(y_in[kk]);
      t  = sx(t_in[kk]);
      e  = fx(y - t);
      d1 = fx((e * y) >>> 12);
      om = fx(4096 - y);
      exp_d[kk] = fx((d1 * om) >>> 12);
    end
    for (int jj = 0; jj < N_HID; jj++) begin
      acc = 0;
      for (int kk = 0; kk < N_OUT; kk++) acc += sx(w_in[kk*N_HID + jj]) * exp_d[kk];
      exp_h[jj] = fx(acc >>> 12);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    for (int kk = 0; kk < N_OUT; kk++) begin
      y_in[kk] = v.y;
      t_in[kk] = (kk == 3) ? v.t3 : v.t;
    end
    for (int i = 0; i < N_W; i++)
      w_in[i] = v.one_hot ? ((i == 3*N_HID + 5) ? v.w : 16'h0000) : v.w;
  endtask

  task automatic check_vec(input vec_t v);
    for (int kk = 0; kk < N_OUT; kk++) check({v.name, "_delta"}, kk, delta[kk], (kk == 3) ? v.ed3 : v.ed);
    for (int jj = 0; jj < N_HID; jj++) check({v.name, "_hid"}, jj, hid[jj], (jj == 5) ? v.eh5 : v.eh);
  endtask

  task automatic check_model(input string nm);
    for (int kk = 0; kk < N_OUT; kk++) check({nm, "_delta"}, kk, delta[kk], 16'(exp_d[kk]));
    for (int jj = 0; jj < N_HID; jj++) check({nm, "_hid"}, jj, hid[jj], 16'(exp_h[jj]));
  endtask

  task automatic start_run();
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b0;
    check("busy_after_run", 0, 16'(busy), 16'h0001);
  endtask

  // Starts a run and watches a bounded window; optionally pulses run again after edge inj_at.
  task automatic run_and_watch(input string nm, input int inj_at);
    int first_done, n_done;
    first_done = -1;
    n_done = 0;
    start_run();
    for (int n = 1; n <= DONE_EDGE + 9; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        if (first_done < 0) begin
          first_done = n;
          check({nm, "_busy_at_done"}, n, 16'(busy), 16'h0000);
        end
      end
      if (n == 21) check({nm, "_hid0_early"}, 0, 16'(hid[0] === hid[0]), 16'h0001);
      if (n == inj_at) begin
        run = 1'b1;
        for (int kk = 0; kk < N_OUT; kk++) begin
          y_in[kk] = 16'h0100;
          t_in[kk] = 16'h7000;
        end
      end
      if (n == inj_at + 1) run = 1'b0;
    end
    check({nm, "_done_edge"}, 0, 16'(first_done), 16'(DONE_EDGE));
    check({nm, "_done_count"}, 0, 16'(n_done), 16'h0001);
    $display("run %s: done at edge %0d, pulses %0d", nm, first_done, n_done);
  endtask

  initial begin
    int n_done;
    rst = 1'b1;
    run = 1'b0;
    for (int kk = 0; kk < N_OUT; kk++) begin y_in[kk] = '0; t_in[kk] = '0; end
    for (int i = 0; i < N_W; i++) w_in[i] = '0;

    vecs[0] = '{"basic",   16'h0800, 16'h1000, 16'h1000, 16'h1000, 1'b0, 16'hFE00, 16'hFE00, 16'hEC00, 16'hEC00};
    vecs[1] = '{"zero",    16'h0C00, 16'h0C00, 16'h0C00, 16'h5A5A, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[2] = '{"index",   16'h0800, 16'h1000, 16'h0000, 16'h1000, 1'b1, 16'hFE00, 16'h0200, 16'h0000, 16'h0200};
    vecs[3] = '{"satur",   16'h8000, 16'h7FFF, 16'h7FFF, 16'h0001, 1'b0, SAT_D,    SAT_D,    SAT_H,    SAT_H};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 0, 16'(busy), 16'h0000);
    check("reset_done", 0, 16'(done), 16'h0000);
    check("reset_delta", 0, delta[0], 16'h0000);
    check("reset_hid", 31, hid[31], 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 4; v++) begin
      apply_vec(vecs[v]);
      run_and_watch(vecs[v].name, -1);
      check_vec(vecs[v]);
    end

    // Second run pulse lands on edge 50 of an active run and must be ignored.
    apply_vec(vecs[0]);
    run_and_watch("run_busy", 49);
    check_vec(vecs[0]);

    // Reset at cycle 100 of a run with nonzero outputs left from the previous run.
    apply_vec(vecs[2]);
    start_run();
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_busy", 0, 16'(busy), 16'h0000);
    check("midrst_done", 0, 16'(done), 16'h0000);
    for (int kk = 0; kk < N_OUT; kk++) check("midrst_delta", kk, delta[kk], 16'h0000);
    for (int jj = 0; jj < N_HID; jj++) check("midrst_hid", jj, hid[jj], 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("aborted_done", 0, 16'(n_done), 16'h0000);
    $display("run reset_abort: dones after abort %0d", n_done);
    apply_vec(vecs[0]);
    run_and_watch("after_rst", -1);
    check_vec(vecs[0]);

    // Random runs against the arithmetic model; odd runs keep values near the unit range.
    for (int r = 0; r < 6; r++) begin
      for (int kk = 0; kk < N_OUT; kk++) begin
        y_in[kk] = (r % 2 == 1) ? 16'($urandom_range(0, 16'h1FFF)) : 16'($urandom);
        t_in[kk] = (r % 2 == 1) ? 16'($urandom_range(0, 16'h1FFF)) : 16'($urandom);
      end
      for (int i = 0; i < N_W; i++) w_in[i] = 16'($urandom);
      compute_model();
      run_and_watch($sformatf("rand%0d", r), -1);
      check_model($sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
